// File: rtl/gate_model_bist_if.sv
// Bus between the gate-model BIST wrapper and its environment.
// The master side drives start/num_pat/response; the slave side is the BIST engine.
interface gate_model_bist_if #(
    parameter int N_IN  = 18,
    parameter int N_OUT = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_pat;
    logic [N_IN-1:0]  pattern;
    logic [N_OUT-1:0] response;
    logic             busy;
    logic             done;
    logic [N_OUT-1:0] signature;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output start, num_pat, response,
        input  pattern, busy, done, signature, pat_cnt
    );

    modport slave (
        input  start, num_pat, response,
        output pattern, busy, done, signature, pat_cnt
    );
endinterface

// File: rtl/gate_model_bist.sv
// LFSR stimulus / MISR compaction self-test wrapper for combinational gate models.
// Optional macro GM_BIST_PIPE_EN registers the model response ahead of the MISR.
module gate_model_bist #(
    parameter int               N_IN      = 18,
    parameter int               N_OUT     = 10,
    parameter int               CNT_W     = 16,
    parameter logic [N_IN-1:0]  LFSR_POLY = 18'h30000,
    parameter logic [N_IN-1:0]  LFSR_SEED = 18'h00001,
    parameter logic [N_OUT-1:0] MISR_POLY = 10'h240
) (
    input logic              clk,
    input logic              rst_n,
    gate_model_bist_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
`ifdef GM_BIST_PIPE_EN
    localparam logic [2:0] S_FLUSH = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0]  SEED_C = (LFSR_SEED == {N_IN{1'b0}}) ?
                                          {{(N_IN-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [N_IN-1:0] lfsr_step(input logic [N_IN-1:0] s);
        return {s[N_IN-2:0], ^(s & LFSR_POLY)};
    endfunction

    function automatic logic [N_OUT-1:0] misr_step(input logic [N_OUT-1:0] m,
                                                   input logic [N_OUT-1:0] r);
        return {m[N_OUT-2:0], ^(m & MISR_POLY)} ^ r;
    endfunction

    logic [2:0]       state_r, state_nxt_s;
    logic [N_IN-1:0]  lfsr_r, lfsr_nxt_s;
    logic [N_OUT-1:0] misr_r, misr_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] num_r, num_nxt_s;
    logic [CNT_W-1:0] num_m1_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
`ifdef GM_BIST_PIPE_EN
    logic [N_OUT-1:0] resp_r, resp_nxt_s;
    logic             first_r, first_nxt_s;
`endif

    assign num_m1_s = num_r - ONE_C;

    // Next-state and datapath update for the session FSM.
    always_comb begin
        state_nxt_s = state_r;
        lfsr_nxt_s  = lfsr_r;
        misr_nxt_s  = misr_r;
        cnt_nxt_s   = cnt_r;
        num_nxt_s   = num_r;
`ifdef GM_BIST_PIPE_EN
        resp_nxt_s  = resp_r;
        first_nxt_s = first_r;
`endif
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    num_nxt_s   = bus.num_pat;
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LOAD: begin
                lfsr_nxt_s = SEED_C;
                misr_nxt_s = {N_OUT{1'b0}};
                cnt_nxt_s  = {CNT_W{1'b0}};
`ifdef GM_BIST_PIPE_EN
                first_nxt_s = 1'b1;
`endif
                if (num_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_nxt_s = lfsr_step(lfsr_r);
`ifdef GM_BIST_PIPE_EN
                // The register is empty on the first RUN cycle, so nothing is compacted yet.
                resp_nxt_s  = bus.response;
                first_nxt_s = 1'b0;
                if (!first_r) begin
                    misr_nxt_s = misr_step(misr_r, resp_r);
                    cnt_nxt_s  = cnt_r + ONE_C;
                end else begin
                    cnt_nxt_s  = cnt_r;
                end
                if (cnt_nxt_s == num_m1_s) begin
                    state_nxt_s = S_FLUSH;
                end else begin
                    state_nxt_s = S_RUN;
                end
`else
                misr_nxt_s = misr_step(misr_r, bus.response);
                cnt_nxt_s  = cnt_r + ONE_C;
                if (cnt_r == num_m1_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
`endif
            end
`ifdef GM_BIST_PIPE_EN
            S_FLUSH: begin
                misr_nxt_s  = misr_step(misr_r, resp_r);
                cnt_nxt_s   = cnt_r + ONE_C;
                state_nxt_s = S_DONE;
            end
`endif
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
        done_nxt_s = (state_nxt_s == S_DONE);
    end

    // State and output registers; reset abandons any session in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            lfsr_r  <= SEED_C;
            misr_r  <= {N_OUT{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            num_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef GM_BIST_PIPE_EN
            resp_r  <= {N_OUT{1'b0}};
            first_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            lfsr_r  <= lfsr_nxt_s;
            misr_r  <= misr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            num_r   <= num_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
`ifdef GM_BIST_PIPE_EN
            resp_r  <= resp_nxt_s;
            first_r <= first_nxt_s;
`endif
        end
    end

    assign bus.pattern   = lfsr_r;
    assign bus.signature = misr_r;
    assign bus.pat_cnt   = cnt_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_gate_model_bist.sv
// Directed bench for gate_model_bist: 4-in/4-out toy gate model, 8-bit pattern counter.
module tb_gate_model_bist;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int CW = 8;
`ifdef GM_BIST_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic resp_en;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gate_model_bist_if #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) bus ();

    gate_model_bist #(
        .N_IN(NI), .N_OUT(NO), .CNT_W(CW),
        .LFSR_POLY(4'hC), .LFSR_SEED(4'h1), .MISR_POLY(4'h9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Toy combinational gate model attached to the pattern bus.
    function automatic logic [3:0] gm(input logic [3:0] p);
        return {~p[1], p[2] | p[0], p[1] & p[2], p[0] ^ p[3]};
    endfunction

    always_comb bus.response = resp_en ? gm(bus.pattern) : 4'h0;

    // Reference signature straight from the LFSR/MISR equations.
    function automatic logic [3:0] model_sig(input int n, input logic en);
        logic [3:0] l;
        logic [3:0] m;
        l = 4'h1;
        m = 4'h0;
        for (int i = 0; i < n; i++) begin
            m = {m[2:0], ^(m & 4'h9)} ^ (en ? gm(l) : 4'h0);
            l = {l[2:0], ^(l & 4'hC)};
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue start and count cycles from the start edge until done is seen.
    task automatic run_session(input logic [7:0] np, output int lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_pat = np;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        check("done_cleared_on_start", {31'd0, bus.done}, 32'd0);
        while (!bus.done && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0] np;
        logic       en;
        logic [3:0] sig;
        logic [7:0] cnt;
        logic [3:0] pat;
    } vec_t;

    vec_t       vt [7];
    logic [3:0] seq [7];
    logic [3:0] sig_hold;
    int         lat;
    int         edges;

    initial begin
        vt[0] = '{np: 8'd1,   en: 1'b1, sig: 4'hD,             cnt: 8'd1,   pat: 4'h2};
        vt[1] = '{np: 8'd2,   en: 1'b1, sig: 4'hA,             cnt: 8'd2,   pat: 4'h4};
        vt[2] = '{np: 8'd3,   en: 1'b1, sig: 4'h9,             cnt: 8'd3,   pat: 4'h9};
        vt[3] = '{np: 8'd7,   en: 1'b1, sig: model_sig(7, 1'b1),   cnt: 8'd7,   pat: 4'hA};
        vt[4] = '{np: 8'd100, en: 1'b0, sig: 4'h0,             cnt: 8'd100, pat: 4'h7};
        vt[5] = '{np: 8'd100, en: 1'b1, sig: model_sig(100, 1'b1), cnt: 8'd100, pat: 4'h7};
        vt[6] = '{np: 8'd255, en: 1'b1, sig: model_sig(255, 1'b1), cnt: 8'd255, pat: 4'h1};
        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD};

        bus.start   = 1'b0;
        bus.num_pat = 8'd0;
        resp_en     = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_sig", {28'd0, bus.signature}, 32'h0);
        check("reset_cnt", {24'd0, bus.pat_cnt}, 32'd0);
        check("reset_pattern", {28'd0, bus.pattern}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            resp_en = vt[i].en;
            run_session(vt[i].np, lat);
            check($sformatf("latency_np%0d", vt[i].np), lat, vt[i].np + 2 + EXTRA);
            check($sformatf("sig_np%0d", vt[i].np), {28'd0, bus.signature}, {28'd0, vt[i].sig});
            check($sformatf("cnt_np%0d", vt[i].np), {24'd0, bus.pat_cnt}, {24'd0, vt[i].cnt});
            check($sformatf("pattern_np%0d", vt[i].np), {28'd0, bus.pattern}, {28'd0, vt[i].pat});
            check($sformatf("busy_end_np%0d", vt[i].np), {31'd0, bus.busy}, 32'd0);
        end
        resp_en = 1'b1;

        // Outputs hold while sitting in DONE.
        sig_hold = bus.signature;
        repeat (3) @(posedge clk);
        #1;
        check("done_held", {31'd0, bus.done}, 32'd1);
        check("sig_held", {28'd0, bus.signature}, {28'd0, sig_hold});

        // num_pat=0: LOAD goes straight to DONE, pattern stays at the seed.
        run_session(8'd0, lat);
        check("latency_np0", lat, 2);
        check("sig_np0", {28'd0, bus.signature}, 32'h0);
        check("cnt_np0", {24'd0, bus.pat_cnt}, 32'd0);
        check("pattern_np0", {28'd0, bus.pattern}, 32'h1);

        // Stimulus sequence seen during RUN for num_pat=7.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_pat = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("run_pattern_%0d", i), {28'd0, bus.pattern}, {28'd0, seq[i]});
            @(posedge clk);
        end
        edges = 0;
        while (!bus.done && edges < 20) begin
            @(posedge clk);
            edges++;
        end
        #1;
        check("seq_session_done", {31'd0, bus.done}, 32'd1);

        // Start during RUN is ignored; the original count of 7 completes.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_pat = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges = 1;
        repeat (4) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_pat = 8'd5;
        @(posedge clk);
        #1;
        edges++;
        bus.start = 1'b0;
        while (!bus.done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ignore_start_latency", edges, 9 + EXTRA);
        check("ignore_start_cnt", {24'd0, bus.pat_cnt}, 32'd7);
        check("ignore_start_sig", {28'd0, bus.signature}, {28'd0, model_sig(7, 1'b1)});

        // Reset in the middle of a session abandons it.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_pat = 8'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("mid_run_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_reset_done", {31'd0, bus.done}, 32'd0);
        check("mid_reset_sig", {28'd0, bus.signature}, 32'h0);
        check("mid_reset_pattern", {28'd0, bus.pattern}, 32'h1);
        check("mid_reset_cnt", {24'd0, bus.pat_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
